tx_serializer: RTL and testbench
================================

# tx_serializer

Transmit-side serializer for the I2S transceiver. It sits directly downstream of `ws_control` and the Tx FIFO. On each word-select edge that `ws_control` qualifies with `Tx_ren`, it pops one word from the Tx FIFO and shifts it out MSB-first on `sd`. Alignment follows `OP.standard`: I2S (one-bit delay) or MSB-justified. It also flags FIFO underrun and slot-length mismatches.

## Interface
Parameters:
- `WMAX`, 32: maximum word/slot width in bits; Tx FIFO data width.

Ports:
- `sclk`  in  1  serial bit clock. All state updates on its negedge, matching `ws_gen`/`ws_control`.
- `preset`  in  1  asynchronous, active-low reset.
- `OP`  in  `OP_t`  operating config; uses `mode`, `frame_size`, `standard`.
- `ws`  in  1  word select (from `ws_gen` in MT, from pad in ST).
- `Tx_ren`  in  1  read enable from `ws_control` (high while ws state is L or R in MT/ST).
- `Tx_data`  in  `WMAX`  head word of first-word-fall-through Tx FIFO; valid when `!Tx_empty`.
- `Tx_empty`  in  1  Tx FIFO empty.
- `err_clr`  in  1  synchronous clear of sticky flags.
- `Tx_pop`  out  1  one-cycle FIFO pop strobe (combinational).
- `sd`  out  1  serial data out.
- `underrun`  out  1  sticky: a slot started with the FIFO empty.
- `frame_err`  out  1  sticky: an active slot ended with the wrong bit count.

## Operation
- **Active:** `OP.mode` is MT or ST. When not active, `Tx_pop=0`, `sd=0`, the shift register is cleared each cycle, and flags hold.
- **Word length N:** 16 if `frame_size==f16bits`, otherwise 32.
- **Aligned word:** `Tx_data` if N=32, otherwise `{Tx_data[15:0],16'h0}`.
- **Edge detect:** `ws_q` registers `ws`. `edge = ws ^ ws_q`.
- **Load** (`load = active & edge & Tx_ren`):
  - `!Tx_empty`:
    - `Tx_pop=1`.
    - Shift register ← aligned word (I2S), or aligned word << 1 (MSB).
    - `slot_active` ← 1.
  - `Tx_empty`:
    - No pop.
    - Shift register ← 0.
    - `underrun` ← 1.
    - `slot_active` ← 1.
- **Edge without load:** `slot_active` ← 0; the shift register keeps shifting.
- **Otherwise:** shift register ← shift register << 1, zero fill. Bits beyond N therefore drive 0.
- **`sd`:**
  - I2S: `sd = shreg[WMAX-1]`. The MSB appears the cycle after the edge; the previous LSB occupies the edge cycle.
  - MSB-justified: `sd = load ? aligned[WMAX-1] : shreg[WMAX-1]`. The MSB coincides with the ws edge, with a combinational path from `Tx_data`.
- **Bit counter** (6 bits): ← 1 on any edge; otherwise +1, saturating at 63.
- **`frame_err`:** set on an edge when `slot_active==1` and `bit_cnt != N`. The first edge after reset never flags.
- **Sticky flags:** `err_clr` clears both flags. A set event in the same cycle wins over the clear.

## Timing
- Reset values: `ws_q=0`, shift register 0, `bit_cnt=0`, `slot_active=0`, `sd=0`, `Tx_pop=0`, `underrun=0`, `frame_err=0`.
- Pop-to-MSB latency: 0 cycles (MSB) or 1 cycle (I2S) after the `Tx_pop` cycle.
- A word occupies exactly N `sd` bit periods. The remaining slot bits are 0.
- Exactly one pop per qualified ws edge. Never two pops in consecutive cycles unless ws toggles every cycle.
- Mid-operation reset: all state zeroes immediately. The first edge after release is treated as a fresh start with no `frame_err`.
- Mono mode: only edges where `Tx_ren=1` load. L→IDLE edges do not pop; they only clear `slot_active`.

## Structure
- `ctrl_pkg` (existing) supplies `OP_t`, the `mode` values (MT/ST/MR/SR), `frame_size` values and `standard` values.
- Add to `ctrl_pkg`: constants `W16=16` and `W32=32`, plus a function returning N from `frame_size`.
- One optional sub-module: `ws_edge_det`, which produces `ws_q` and `edge`.

## Test plan
- MT, MSB, f32bits, stereo; FIFO holds `32'hA5A5_0F0F`, `32'h8000_0001` → one pop per ws edge; `sd` shows A5A50F0F MSB-first starting in the edge cycle, then 80000001; no flags.
- Same words in I2S standard → each MSB appears one sclk after its ws edge; 80000001's LSB coincides with the next edge.
- f16bits, `Tx_data=32'hXXXX_C3C3` → `sd` shows C3C3 over 16 bits; `frame_err=0` with a 16-cycle slot.
- Empty FIFO at a qualified edge → `Tx_pop=0`, `sd=0` for the whole slot, `underrun=1` until `err_clr`, then 0.
- ST mode with an external ws edge after 20 cycles while N=32 → `frame_err=1`; reset asserted mid-word → `sd=0` and `Tx_pop=0` immediately.
- MR mode with toggling ws → `Tx_pop` never asserts and `sd` stays 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared I2S transceiver control types: operating config, mode/frame/standard encodings,
// and the word-length helper used by the serializers.
package ctrl_pkg;

    typedef enum logic [1:0] {
        MT = 2'd0,
        ST = 2'd1,
        MR = 2'd2,
        SR = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        f16bits = 2'd0,
        f24bits = 2'd1,
        f32bits = 2'd2
    } frame_size_t;

    typedef enum logic {
        I2S = 1'b0,
        MSB = 1'b1
    } standard_t;

    typedef struct packed {
        mode_t       mode;
        frame_size_t frame_size;
        standard_t   standard;
    } OP_t;

    localparam int unsigned W16 = 16;
    localparam int unsigned W32 = 32;

    // Only 16-bit frames carry a short word; every other frame size is a 32-bit word.
    function automatic logic [5:0] word_len(input frame_size_t fs);
        return (fs == f16bits) ? 6'(W16) : 6'(W32);
    endfunction

endpackage

// File: rtl/ws_edge_det.sv
// Word-select edge detector: registers ws on the sclk falling edge and flags any change.
module ws_edge_det (
    input  logic sclk,
    input  logic preset,
    input  logic ws,
    output logic ws_edge
);

    logic ws_q;

    always_ff @(negedge sclk or negedge preset) begin
        if (!preset) begin
            ws_q <= 1'b0;
        end else begin
            ws_q <= ws;
        end
    end

    assign ws_edge = ws ^ ws_q;

endmodule

// File: rtl/tx_serializer.sv
// Tx serializer: pops one FIFO word per qualified ws edge and shifts it out MSB-first on sd,
// in I2S (one-bit delay) or MSB-justified alignment, flagging underrun and slot-length errors.
module tx_serializer
    import ctrl_pkg::*;
#(
    parameter int unsigned WMAX = 32
) (
    input  logic            sclk,
    input  logic            preset,
    input  OP_t             OP,
    input  logic            ws,
    input  logic            Tx_ren,
    input  logic [WMAX-1:0] Tx_data,
    input  logic            Tx_empty,
    input  logic            err_clr,
    output logic            Tx_pop,
    output logic            sd,
    output logic            underrun,
    output logic            frame_err
);

    logic            ws_edge;
    logic            active;
    logic            load;
    logic [5:0]      n_len;
    logic [WMAX-1:0] aligned;
    logic [WMAX-1:0] shreg;
    logic [WMAX-1:0] shreg_nxt;
    logic [5:0]      bit_cnt;
    logic            slot_active;

    ws_edge_det u_ws_edge_det (
        .sclk    (sclk),
        .preset  (preset),
        .ws      (ws),
        .ws_edge (ws_edge)
    );

    // Load is gated by reset so a held-low preset silences Tx_pop and sd at once.
    always_comb begin
        active  = (OP.mode == MT) || (OP.mode == ST);
        n_len   = word_len(OP.frame_size);
        aligned = (n_len == 6'(W32)) ? Tx_data : {Tx_data[W16-1:0], {(WMAX-W16){1'b0}}};
        load    = preset & active & ws_edge & Tx_ren;
        Tx_pop  = load & ~Tx_empty;
    end

    always_comb begin
        sd = 1'b0;
        if (active) begin
            if (OP.standard == MSB && load) begin
                sd = Tx_pop & aligned[WMAX-1];
            end else begin
                sd = shreg[WMAX-1];
            end
        end
    end

    // MSB-justified drives the MSB combinationally in the edge cycle, so the register keeps the rest.
    always_comb begin
        shreg_nxt = shreg << 1;
        if (!active) begin
            shreg_nxt = '0;
        end else if (load) begin
            if (Tx_empty) begin
                shreg_nxt = '0;
            end else if (OP.standard == MSB) begin
                shreg_nxt = aligned << 1;
            end else begin
                shreg_nxt = aligned;
            end
        end
    end

    always_ff @(negedge sclk or negedge preset) begin
        if (!preset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            slot_active <= 1'b0;
        end else begin
            shreg <= shreg_nxt;

            if (ws_edge) begin
                bit_cnt <= 6'd1;
            end else if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            if (!active) begin
                slot_active <= 1'b0;
            end else if (load) begin
                slot_active <= 1'b1;
            end else if (ws_edge) begin
                slot_active <= 1'b0;
            end
        end
    end

    // Set events take priority over err_clr in the same cycle.
    always_ff @(negedge sclk or negedge preset) begin
        if (!preset) begin
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (load && Tx_empty) begin
                underrun <= 1'b1;
            end else if (err_clr) begin
                underrun <= 1'b0;
            end

            if (active && ws_edge && slot_active && (bit_cnt != n_len)) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: FIFO model plus per-cycle scoreboard of expected sd bits, pops and flags.
module tb_tx_serializer;
    import ctrl_pkg::*;

    localparam int unsigned WMAX = 32;

    logic            sclk = 1'b0;
    logic            preset;
    OP_t             op;
    logic            ws;
    logic            tx_ren;
    logic [WMAX-1:0] tx_data;
    logic            tx_empty;
    logic            err_clr;
    logic            tx_pop;
    logic            sd;
    logic            underrun;
    logic            frame_err;

    tx_serializer #(.WMAX(WMAX)) dut (
        .sclk      (sclk),
        .preset    (preset),
        .OP        (op),
        .ws        (ws),
        .Tx_ren    (tx_ren),
        .Tx_data   (tx_data),
        .Tx_empty  (tx_empty),
        .err_clr   (err_clr),
        .Tx_pop    (tx_pop),
        .sd        (sd),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] fifo_q[$];
    bit          exp_q[$];
    logic        prev_ws;
    int          cnt_m;
    bit          slot_m;
    bit          und_m;
    bit          ferr_m;
    logic        ws_drv;
    logic        rst_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic cycle(input logic ws_v, input logic ren_v, input logic clr_v);
        logic        act, edge_v, ld, epop, esd;
        int          n;
        logic [31:0] word;
        @(posedge sclk);
        preset   = rst_drv;
        ws       = ws_v;
        tx_ren   = ren_v;
        err_clr  = clr_v;
        tx_empty = (fifo_q.size() == 0);
        tx_data  = tx_empty ? 32'hDEAD_BEEF : fifo_q[0];
        #2;
        if (!rst_drv) begin
            exp_q.delete();
            prev_ws = 1'b0;
            cnt_m   = 0;
            slot_m  = 0;
            und_m   = 0;
            ferr_m  = 0;
        end
        act    = (op.mode == MT) || (op.mode == ST);
        n      = (op.frame_size == f16bits) ? 16 : 32;
        edge_v = (ws_v != prev_ws);
        ld     = rst_drv && act && edge_v && ren_v;
        epop   = ld && !tx_empty;
        word   = (n == 32) ? tx_data : (tx_data << 16);
        esd    = 1'b0;
        if (!rst_drv || !act) begin
            exp_q.delete();
        end else if (ld) begin
            if (op.standard == MSB) esd = epop ? word[31] : 1'b0;
            else if (exp_q.size() != 0) esd = exp_q.pop_front();
            exp_q.delete();
            if (epop) begin
                for (int i = (op.standard == MSB) ? 30 : 31; i >= 32 - n; i--) exp_q.push_back(word[i]);
            end
        end else if (exp_q.size() != 0) begin
            esd = exp_q.pop_front();
        end

        check("tx_pop", {31'd0, tx_pop}, {31'd0, epop});
        check("sd", {31'd0, sd}, {31'd0, esd});
        check("underrun", {31'd0, underrun}, {31'd0, und_m});
        check("frame_err", {31'd0, frame_err}, {31'd0, ferr_m});

        if (rst_drv) begin
            if (act && edge_v && slot_m && cnt_m != n) ferr_m = 1;
            else if (clr_v) ferr_m = 0;
            if (ld && tx_empty) und_m = 1;
            else if (clr_v) und_m = 0;
            if (!act) slot_m = 0;
            else if (ld) slot_m = 1;
            else if (edge_v) slot_m = 0;
            cnt_m   = edge_v ? 1 : ((cnt_m == 63) ? 63 : cnt_m + 1);
            prev_ws = ws_v;
        end
        if (epop) void'(fifo_q.pop_front());
    endtask

    task automatic slot(input int len, input logic ren_v);
        ws_drv = ~ws_drv;
        cycle(ws_drv, ren_v, 1'b0);
        for (int i = 1; i < len; i++) cycle(ws_drv, ren_v, 1'b0);
    endtask

    task automatic idle(input int len);
        for (int i = 0; i < len; i++) cycle(ws_drv, 1'b0, 1'b0);
    endtask

    initial begin
        op      = '{mode: MT, frame_size: f32bits, standard: MSB};
        ws_drv  = 1'b0;
        rst_drv = 1'b0;
        preset  = 1'b0;
        ws      = 1'b0;
        tx_ren  = 1'b0;
        err_clr = 1'b0;
        tx_data = '0;
        tx_empty = 1'b1;
        prev_ws = 1'b0;
        cnt_m = 0; slot_m = 0; und_m = 0; ferr_m = 0;

        // reset state
        idle(2);
        rst_drv = 1'b1;
        idle(3);

        // MT, MSB-justified, 32-bit stereo
        fifo_q.push_back(32'hA5A5_0F0F);
        fifo_q.push_back(32'h8000_0001);
        fifo_q.push_back(32'h1234_5678);
        slot(32, 1'b1);
        slot(32, 1'b1);
        slot(32, 1'b1);
        slot(4, 1'b0);

        // same words in I2S alignment
        op.standard = I2S;
        fifo_q.push_back(32'hA5A5_0F0F);
        fifo_q.push_back(32'h8000_0001);
        slot(32, 1'b1);
        slot(32, 1'b1);
        slot(4, 1'b0);

        // 16-bit frames, both standards
        op.frame_size = f16bits;
        fifo_q.push_back(32'h1234_C3C3);
        fifo_q.push_back(32'hBEEF_5A5A);
        slot(16, 1'b1);
        slot(16, 1'b1);
        slot(3, 1'b0);
        op.standard = MSB;
        fifo_q.push_back(32'hFFFF_C3C3);
        slot(16, 1'b1);
        slot(3, 1'b0);

        // underrun on an empty FIFO; set wins over a same-cycle clear
        op.frame_size = f32bits;
        ws_drv = ~ws_drv;
        cycle(ws_drv, 1'b1, 1'b1);
        for (int i = 1; i < 32; i++) cycle(ws_drv, 1'b1, 1'b0);
        slot(2, 1'b0);
        cycle(ws_drv, 1'b0, 1'b1);
        idle(2);

        // ST, short slot then mid-word reset
        op.mode = ST;
        op.standard = I2S;
        fifo_q.push_back(32'hCAFE_F00D);
        fifo_q.push_back(32'h0F0F_F0F0);
        slot(20, 1'b1);
        slot(10, 1'b1);
        rst_drv = 1'b0;
        ws_drv  = 1'b0;
        idle(2);
        rst_drv = 1'b1;
        fifo_q.delete();
        fifo_q.push_back(32'h8421_1248);
        idle(1);
        slot(32, 1'b1);
        slot(2, 1'b0);

        // MR: receive mode never pops or drives sd
        op.mode = MR;
        fifo_q.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) slot(3, 1'b1);
        check("fifo_untouched", fifo_q.size(), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
